// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to count the 2*w restoring steps (0 .. 2*w-1).
   function automatic int unsigned cnt_width(input int unsigned w);
      return (2 * w > 1) ? $clog2(2 * w) : 1;
   endfunction

endpackage

// File: rtl/divide_step.sv
// One restoring-division step: shift in the next dividend bit, compare, subtract.
module divide_step #(
   parameter int Width = 4
) (
   input  logic [Width:0]   i_rem,
   input  logic             i_bit,
   input  logic [Width-1:0] i_divisor,
   output logic [Width:0]   o_rem_c,
   output logic             o_q_bit_c
);

   logic [Width+1:0] w_shift;
   logic             w_ge;

   // Shift/compare/subtract; the extra top bit keeps the compare overflow-free.
   always_comb begin
      w_shift   = {i_rem, i_bit};
      w_ge      = (w_shift >= {2'b00, i_divisor});
      o_q_bit_c = w_ge;
      o_rem_c   = w_ge ? (Width+1)'(w_shift - {2'b00, i_divisor})
                       : (Width+1)'(w_shift);
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: 2*Width-bit dividend by Width-bit divisor.
module seq_divider
   import div_pkg::*;
#(
   parameter int Width = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2*Width-1:0]   dividend,
   input  logic [Width-1:0]     divisor,
   output logic                 busy,
   output logic                 done,
   output logic [2*Width-1:0]   quotient,
   output logic [Width-1:0]     remainder,
   output logic                 div_by_zero
);

   localparam int unsigned QW   = 2 * Width;
   localparam int unsigned CntW = cnt_width(Width);

   state_t             r_state;
   state_t             w_next_state;
   logic               w_accept;
   logic               w_last;

   logic [QW-1:0]      r_dvd;
   logic [Width-1:0]   r_divisor;
   logic [Width:0]     r_rem;
   logic [QW-2:0]      r_quo;
   logic [CntW-1:0]    r_cnt;

   logic [Width:0]     w_rem;
   logic               w_q_bit;
   logic [QW-1:0]      w_quo_next;

   assign w_quo_next = {r_quo, w_q_bit};

   divide_step #(.Width(Width)) u_step (
      .i_rem      (r_rem),
      .i_bit      (r_dvd[QW-1]),
      .i_divisor  (r_divisor),
      .o_rem_c    (w_rem),
      .o_q_bit_c  (w_q_bit)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic; a zero divisor skips CALC entirely.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = (divisor == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (r_cnt == CntW'(QW - 1)) begin
               w_last       = 1'b1;
               w_next_state = DONE;
            end
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Datapath and registered outputs; results only move at the end of an operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dvd       <= '0;
         r_divisor   <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_cnt       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         busy <= (w_next_state == CALC);
         done <= (w_next_state == DONE);
         if (w_accept) begin
            r_dvd     <= dividend;
            r_divisor <= divisor;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            if (divisor == '0) begin
               quotient    <= '1;
               remainder   <= dividend[Width-1:0];
               div_by_zero <= 1'b1;
            end
         end else if (r_state == CALC) begin
            r_dvd <= {r_dvd[QW-2:0], 1'b0};
            r_rem <= w_rem;
            r_quo <= w_quo_next[QW-2:0];
            r_cnt <= r_cnt + CntW'(1);
            if (w_last) begin
               quotient    <= w_quo_next;
               remainder   <= w_rem[Width-1:0];
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (Width=4) against an arithmetic reference model.
module tb_seq_divider;

   localparam int W = 4;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [2*W-1:0] dividend;
   logic [W-1:0]   divisor;
   logic           busy;
   logic           done;
   logic [2*W-1:0] quotient;
   logic [W-1:0]   remainder;
   logic           div_by_zero;

   int n_cmp;
   int n_err;

   // Reference model: the results the outputs should currently hold.
   logic [2*W-1:0] m_q;
   logic [W-1:0]   m_r;
   logic           m_z;

   seq_divider #(.Width(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One division; inj >= 0 pulses a competing start (50/5) at that CALC sample.
   task automatic run_div(input logic [2*W-1:0] a, input logic [W-1:0] b, input int inj);
      int idx;
      int busy_cnt;
      int exp_lat;
      logic [2*W-1:0] eq;
      logic [W-1:0]   er;
      logic           ez;
      if (b == '0) begin
         eq = '1; er = a[W-1:0]; ez = 1'b1; exp_lat = 0;
      end else begin
         eq = a / {4'd0, b}; er = W'(a % {4'd0, b}); ez = 1'b0; exp_lat = 2 * W;
      end
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      start = 1'b0;
      dividend = 8'($urandom_range(255, 0));
      divisor  = 4'($urandom_range(15, 0));
      idx = 0; busy_cnt = 0;
      while (!done && idx < 40) begin
         if (busy) busy_cnt++;
         check("hold_quotient", quotient, m_q);
         check("hold_remainder", remainder, m_r);
         if (idx == inj) begin
            start = 1'b1; dividend = 8'd50; divisor = 4'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         idx++;
      end
      start = 1'b0;
      check("done_seen", done, 1'b1);
      check("done_latency", idx, exp_lat);
      check("busy_cycles", busy_cnt, exp_lat);
      check("busy_with_done", busy & done, 1'b0);
      check("quotient", quotient, eq);
      check("remainder", remainder, er);
      check("div_by_zero", div_by_zero, ez);
      m_q = eq; m_r = er; m_z = ez;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("idle_done", done, 1'b0);
         check("idle_busy", busy, 1'b0);
         check("idle_quotient", quotient, m_q);
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      m_q = '0; m_r = '0; m_z = 1'b0;
      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_quotient", quotient, 8'd0);
      check("rst_remainder", remainder, 4'd0);
      check("rst_dbz", div_by_zero, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      run_div(8'd200, 4'd7, -1);
      run_div(8'd255, 4'd1, -1);
      run_div(8'd3,   4'd9, -1);
      run_div(8'd13,  4'd0, -1);
      run_div(8'd100, 4'd3, 2);

      // Reset in the middle of a calculation clears outputs without a clock edge.
      start = 1'b1; dividend = 8'd200; divisor = 4'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midcalc_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_quotient", quotient, 8'd0);
      check("arst_remainder", remainder, 4'd0);
      check("arst_dbz", div_by_zero, 1'b0);
      m_q = '0; m_r = '0; m_z = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      run_div(8'd90, 4'd9, -1);

      for (int i = 0; i < 20; i++) begin
         run_div(8'($urandom_range(255, 0)), 4'($urandom_range(15, 0)), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
